// File: rtl/pc_seq_ctrl.sv
// Fetch-stage PC sequencer: owns the fetch PC, picks reset/sequential/redirect/halt/trap sources.
// Optional misaligned-redirect trapping is enabled by defining PC_SEQ_TRAP_EN.
module pc_seq_ctrl #(
    parameter int unsigned         pc_width  = 32,
    parameter logic [pc_width-1:0] RESET_VEC = '0,
    parameter logic [pc_width-1:0] TRAP_VEC  = pc_width'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                pc_rst_n,
    input  logic [6:0]          id_opcode,
    input  logic [pc_width-1:0] id_pc,
    input  logic                id_valid,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [pc_width-1:0] redirect_target,
    input  logic                resume,
    output logic [pc_width-1:0] pc_out,
    output logic                fetch_valid,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                halted,
    output logic [pc_width-1:0] trap_epc
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        TRAP
    } state_t;

    localparam logic [pc_width-1:0] PC_STEP     = pc_width'(4);
    localparam logic [pc_width-1:0] ALIGN_MASK  = ~pc_width'(3);
    localparam logic [6:0]          HALT_OPCODE = 7'h7F;

    state_t              state_q, state_d;
    logic [pc_width-1:0] pc_q, pc_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                halted_q, halted_d;
    logic [pc_width-1:0] resume_pc_q, resume_pc_d;
    logic                halt_hit;
    logic                trap_hit;

    assign halt_hit = id_valid && (id_opcode == HALT_OPCODE);

`ifdef PC_SEQ_TRAP_EN
    logic [pc_width-1:0] trap_epc_q, trap_epc_d;
    assign trap_hit = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign trap_epc = trap_epc_q;
`else
    assign trap_hit = 1'b0;
    assign trap_epc = '0;
`endif

    // Flushes only ever fire from RUN; a redirect (or trap) kills both stages,
    // a halt only kills the younger instruction already fetched into IF/ID.
    always_comb begin
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (halt_hit) begin
                flush_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        halted_d      = halted_q;
        resume_pc_d   = resume_pc_q;
`ifdef PC_SEQ_TRAP_EN
        trap_epc_d    = trap_epc_q;
`endif
        case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
            end
            RUN: begin
                if (trap_hit) begin
                    state_d       = TRAP;
                    pc_d          = TRAP_VEC;
                    fetch_valid_d = 1'b1;
`ifdef PC_SEQ_TRAP_EN
                    trap_epc_d    = redirect_target;
`endif
                end else if (redirect_valid) begin
                    pc_d          = redirect_target & ALIGN_MASK;
                    fetch_valid_d = 1'b1;
                end else if (halt_hit) begin
                    state_d       = HALT;
                    fetch_valid_d = 1'b0;
                    halted_d      = 1'b1;
                    resume_pc_d   = id_pc + PC_STEP;
                end else if (stall) begin
                    fetch_valid_d = 1'b1;
                end else begin
                    pc_d          = pc_q + PC_STEP;
                    fetch_valid_d = 1'b1;
                end
            end
            // Redirects are ignored here: the older branch in EX resolved before the halt reached ID.
            HALT: begin
                if (resume) begin
                    state_d       = RUN;
                    pc_d          = resume_pc_q;
                    halted_d      = 1'b0;
                    fetch_valid_d = 1'b1;
                end
            end
            TRAP: begin
                state_d       = RUN;
                pc_d          = TRAP_VEC + PC_STEP;
                fetch_valid_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            resume_pc_q   <= '0;
`ifdef PC_SEQ_TRAP_EN
            trap_epc_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            resume_pc_q   <= resume_pc_d;
`ifdef PC_SEQ_TRAP_EN
            trap_epc_q    <= trap_epc_d;
`endif
        end
    end

    assign pc_out      = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by random traffic,
// compared against a cycle-level behavioural model of the sequencer rules.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        pc_rst_n;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        resume;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [31:0] trap_epc;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0=booting, 1=running, 2=halted, 3=trap entry
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_fv;
    logic        m_halted;
    logic [31:0] m_rpc;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    pc_seq_ctrl dut (
        .clk             (clk),
        .pc_rst_n        (pc_rst_n),
        .id_opcode       (id_opcode),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .resume          (resume),
        .pc_out          (pc_out),
        .fetch_valid     (fetch_valid),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .halted          (halted),
        .trap_epc        (trap_epc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_mode   = 0;
        m_pc     = RESET_VEC;
        m_fv     = 1'b0;
        m_halted = 1'b0;
        m_rpc    = 32'h0;
        m_epc    = 32'h0;
    endtask

    task automatic modelStep();
        bit trap_en;
`ifdef PC_SEQ_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        if (m_mode == 0) begin
            m_mode = 1;
            m_fv   = 1'b1;
        end else if (m_mode == 1) begin
            if (trap_en && redirect_valid && (redirect_target % 4 != 0)) begin
                m_epc  = redirect_target;
                m_pc   = TRAP_VEC;
                m_fv   = 1'b1;
                m_mode = 3;
            end else if (redirect_valid) begin
                m_pc = redirect_target - (redirect_target % 4);
                m_fv = 1'b1;
            end else if (id_valid && id_opcode == 7'h7F) begin
                m_fv     = 1'b0;
                m_halted = 1'b1;
                m_rpc    = id_pc + 32'd4;
                m_mode   = 2;
            end else if (stall) begin
                m_fv = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                m_fv = 1'b1;
            end
        end else if (m_mode == 2) begin
            if (resume) begin
                m_pc     = m_rpc;
                m_halted = 1'b0;
                m_fv     = 1'b1;
                m_mode   = 1;
            end
        end else begin
            m_pc   = m_pc + 32'd4;
            m_fv   = 1'b1;
            m_mode = 1;
        end
    endtask

    task automatic checkOutput(input string ctx);
        logic exp_fid;
        logic exp_fex;
        exp_fid = 1'b0;
        exp_fex = 1'b0;
        if (m_mode == 1 && redirect_valid) begin
            exp_fid = 1'b1;
            exp_fex = 1'b1;
        end else if (m_mode == 1 && id_valid && id_opcode == 7'h7F) begin
            exp_fid = 1'b1;
        end
        check({ctx, " pc_out"},      pc_out,               m_pc);
        check({ctx, " fetch_valid"}, {31'b0, fetch_valid}, {31'b0, m_fv});
        check({ctx, " halted"},      {31'b0, halted},      {31'b0, m_halted});
        check({ctx, " trap_epc"},    trap_epc,             m_epc);
        check({ctx, " flush_if_id"}, {31'b0, flush_if_id}, {31'b0, exp_fid});
        check({ctx, " flush_id_ex"}, {31'b0, flush_id_ex}, {31'b0, exp_fex});
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the model to the next rising edge.
    task automatic applyStimulus(input logic rst_n, input logic rv, input logic [31:0] tgt,
                                 input logic stl, input logic idv, input logic [6:0] opc,
                                 input logic [31:0] idpc, input logic res, input string ctx);
        @(negedge clk);
        pc_rst_n        = rst_n;
        redirect_valid  = rv;
        redirect_target = tgt;
        stall           = stl;
        id_valid        = idv;
        id_opcode       = opc;
        id_pc           = idpc;
        resume          = res;
        #1;
        if (!pc_rst_n) modelReset();
        checkOutput(ctx);
        if (pc_rst_n) modelStep();
    endtask

    task automatic idle(input string ctx);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, ctx);
    endtask

    initial begin
        logic [31:0] r;
        pc_rst_n        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        stall           = 1'b0;
        id_valid        = 1'b0;
        id_opcode       = 7'h00;
        id_pc           = 32'h0;
        resume          = 1'b0;
        modelReset();

        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "reset");
        check("reset pc_out", pc_out, RESET_VEC);

        idle("boot");
        check("boot fetch_valid", {31'b0, fetch_valid}, 32'h0);
        repeat (4) idle("seq");
        check("seq pc before redirect", pc_out, 32'h0000_000C);

        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "redirect 0x40");
        check("redirect from pc", pc_out, 32'h0000_0010);
        idle("after redirect");
        check("redirect target", pc_out, 32'h0000_0040);
        idle("after redirect+1");

        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "redirect 0x20");
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0, "redirect+stall");
        idle("post redirect+stall");
        check("redirect beats stall", pc_out, 32'h0000_0080);
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "redirect 0x20 b");
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0, "stall");
        idle("after stall");
        check("stall held pc", pc_out, 32'h0000_0020);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 7'h7F, 32'h30, 1'b0, "halt opcode");
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            applyStimulus(1'b1, 1'b1, r, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "halted redirect");
        end
        check("halt flag", {31'b0, halted}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, "resume");
        idle("after resume");
        check("resume pc", pc_out, 32'h0000_0034);

        applyStimulus(1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "misaligned redirect");
        idle("after misaligned");
`ifdef PC_SEQ_TRAP_EN
        check("trap vector", pc_out, TRAP_VEC);
        check("trap epc", trap_epc, 32'h42);
`else
        check("cleared low bits", pc_out, 32'h0000_0040);
`endif
        idle("after misaligned+1");

        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "redirect top");
        idle("at top");
        idle("wrap");
        check("pc wrap", pc_out, 32'h0000_0000);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 7'h7F, 32'h200, 1'b0, "halt b");
        idle("in halt");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "reset mid-halt");
        check("reset clears halted", {31'b0, halted}, 32'h0);
        check("reset pc mid-halt", pc_out, RESET_VEC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, "reset hold");
        idle("release");

        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] tgt;
            logic        stl;
            logic        idv;
            logic [6:0]  opc;
            logic [31:0] idpc;
            logic        res;
            rv   = ($urandom_range(7) == 0);
            tgt  = $urandom;
            stl  = ($urandom_range(3) == 0);
            idv  = ($urandom_range(1) == 1);
            r    = $urandom;
            opc  = ($urandom_range(7) == 0) ? 7'h7F : r[6:0];
            idpc = $urandom & 32'hFFFF_FFFC;
            res  = ($urandom_range(4) == 0);
            applyStimulus(1'b1, rv, tgt, stl, idv, opc, idpc, res, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
